// File: rtl/ciq_pkg.sv
// rtl/ciq_pkg.sv - shared defaults, types and helpers for the CIQ allocator
// Purpose: default geometry of the centralised issue queue, index/count
//          typedefs and a popcount helper used by the allocator.
// Ports:   none (package).
package ciq_pkg;

  localparam int CIQ_DEPTH  = 16;
  localparam int DECODE_NUM = 4;
  localparam int ISSUE_NUM  = 2;
  localparam int ADDR_W     = $clog2(CIQ_DEPTH);
  localparam int CNT_W      = $clog2(CIQ_DEPTH + 1);

  typedef logic [ADDR_W-1:0] ciq_idx_t;
  typedef logic [CNT_W-1:0]  ciq_cnt_t;

  // Vectors up to 32 bits wide; callers zero-extend narrower vectors.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/ciq_pick_first.sv
// rtl/ciq_pick_first.sv - lowest-set-bit picker for the CIQ free vector
// Purpose: returns the indices of the lowest NUM set bits of vec, in
//          ascending order, with a valid bit per returned index.
// Ports:   vec  in  DEPTH      candidate vector (1 = available)
//          idx  out NUM*AW     index j at bits [j*AW +: AW], 0 when unused
//          vld  out NUM        idx j holds a real set-bit index
module ciq_pick_first #(
  parameter int DEPTH = 16,
  parameter int NUM   = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]  vec,
  output logic [NUM*AW-1:0] idx,
  output logic [NUM-1:0]    vld
);

  int cnt;

  always_comb begin
    idx = '0;
    vld = '0;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vec[i] && (cnt < NUM)) begin
        idx[cnt*AW +: AW] = AW'(i);
        vld[cnt]          = 1'b1;
        cnt++;
      end
    end
  end

endmodule

// File: rtl/ciq_alloc_ctrl.sv
// rtl/ciq_alloc_ctrl.sv - CIQ entry allocator with issue release and flush
// Purpose: owns the CIQ free bitmap, grants the lowest free entries to a
//          dispatch group all-or-nothing, reclaims entries on issue and
//          frees everything on flush.
// Optional: CIQ_ALLOC_RELEASE_BYPASS_EN makes entries released this cycle
//           allocatable in the same cycle.
// Ports:   clk, rst_n (async active-low), flush
//          alloc_req/alloc_ready/alloc_addr/alloc_valid  dispatch side
//          rel_vld/rel_addr                              issue release side
//          free_cnt/ciq_full/ciq_empty                   registered status
module ciq_alloc_ctrl #(
  parameter int DECODE_NUM = ciq_pkg::DECODE_NUM,
  parameter int CIQ_DEPTH  = ciq_pkg::CIQ_DEPTH,
  parameter int ISSUE_NUM  = ciq_pkg::ISSUE_NUM,
  parameter int ADDR_W     = $clog2(CIQ_DEPTH),
  parameter int CNT_W      = $clog2(CIQ_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic [DECODE_NUM-1:0]        alloc_req,
  output logic                         alloc_ready,
  output logic [DECODE_NUM*ADDR_W-1:0] alloc_addr,
  output logic [DECODE_NUM-1:0]        alloc_valid,
  input  logic [ISSUE_NUM-1:0]         rel_vld,
  input  logic [ISSUE_NUM*ADDR_W-1:0]  rel_addr,
  output logic [CNT_W-1:0]             free_cnt,
  output logic                         ciq_full,
  output logic                         ciq_empty
);

  import ciq_pkg::*;

  logic [CIQ_DEPTH-1:0]         ciq_free;
  logic [CIQ_DEPTH-1:0]         ciq_free_n;
  logic [CIQ_DEPTH-1:0]         rel_mask;
  logic [CIQ_DEPTH-1:0]         alloc_mask;
  logic [CIQ_DEPTH-1:0]         avail;
  logic [CNT_W-1:0]             avail_cnt;
  logic [CNT_W-1:0]             n_req;
  logic [CNT_W-1:0]             free_cnt_n;
  logic [DECODE_NUM*ADDR_W-1:0] pick_idx;
  logic [DECODE_NUM-1:0]        pick_vld;
  int                           k;

  // Duplicate release addresses simply OR into the same bit.
  always_comb begin
    rel_mask = '0;
    for (int p = 0; p < ISSUE_NUM; p++) begin
      if (rel_vld[p]) rel_mask[rel_addr[p*ADDR_W +: ADDR_W]] = 1'b1;
    end
  end

`ifdef CIQ_ALLOC_RELEASE_BYPASS_EN
  // Only releases of busy entries add capacity; re-releasing a free entry
  // must not be counted twice.
  assign avail     = ciq_free | rel_mask;
  assign avail_cnt = free_cnt + CNT_W'(popcount(32'(rel_mask & ~ciq_free)));
`else
  assign avail     = ciq_free;
  assign avail_cnt = free_cnt;
`endif

  assign n_req       = CNT_W'(popcount(32'(alloc_req)));
  assign alloc_ready = (n_req <= avail_cnt) && !flush;

  ciq_pick_first #(
    .DEPTH (CIQ_DEPTH),
    .NUM   (DECODE_NUM),
    .AW    (ADDR_W)
  ) u_pick (
    .vec (avail),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Compact sparse requests: the k-th requesting slot takes the k-th pick.
  always_comb begin
    alloc_addr  = '0;
    alloc_valid = '0;
    alloc_mask  = '0;
    k           = 0;
    for (int i = 0; i < DECODE_NUM; i++) begin
      if (alloc_req[i]) begin
        alloc_addr[i*ADDR_W +: ADDR_W] = pick_idx[k*ADDR_W +: ADDR_W];
        alloc_valid[i]                 = alloc_ready;
        if (alloc_ready && pick_vld[k]) begin
          alloc_mask[pick_idx[k*ADDR_W +: ADDR_W]] = 1'b1;
        end
        k++;
      end
    end
  end

  // Allocation clear wins over release set: a bypassed entry stays busy, and
  // a stray release of a free entry cannot undo a same-cycle grant of it.
  always_comb begin
    if (flush) ciq_free_n = '1;
    else       ciq_free_n = (ciq_free | rel_mask) & ~alloc_mask;
    free_cnt_n = CNT_W'(popcount(32'(ciq_free_n)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ciq_free  <= '1;
      free_cnt  <= CNT_W'(CIQ_DEPTH);
      ciq_full  <= 1'b0;
      ciq_empty <= 1'b1;
    end else begin
      ciq_free  <= ciq_free_n;
      free_cnt  <= free_cnt_n;
      ciq_full  <= (free_cnt_n == '0);
      ciq_empty <= (free_cnt_n == CNT_W'(CIQ_DEPTH));
    end
  end

endmodule

// File: tb/tb_ciq_alloc_ctrl.sv
// tb/tb_ciq_alloc_ctrl.sv - scoreboard bench for ciq_alloc_ctrl
module tb_ciq_alloc_ctrl;

`ifdef CIQ_ALLOC_RELEASE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  alloc_req = '0;
  logic        alloc_ready;
  logic [15:0] alloc_addr;
  logic [3:0]  alloc_valid;
  logic [1:0]  rel_vld = '0;
  logic [7:0]  rel_addr = '0;
  logic [4:0]  free_cnt;
  logic        ciq_full;
  logic        ciq_empty;

  ciq_alloc_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .alloc_req   (alloc_req),
    .alloc_ready (alloc_ready),
    .alloc_addr  (alloc_addr),
    .alloc_valid (alloc_valid),
    .rel_vld     (rel_vld),
    .rel_addr    (rel_addr),
    .free_cnt    (free_cnt),
    .ciq_full    (ciq_full),
    .ciq_empty   (ciq_empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ready;
    logic [3:0]  req;
    logic [3:0]  valid;
    logic [15:0] addrs;
    logic [4:0]  cnt;
    logic        full;
    logic        empty;
    logic [15:0] free;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference state: one flag per entry, 1 = free.
  bit   m_free[16];
  bit   last_flush;
  bit   last_rv[2];
  int   last_ra[2];
  int   last_alloc[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_vec();
    logic [15:0] v;
    for (int e = 0; e < 16; e++) v[e] = m_free[e];
    return v;
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int e = 0; e < 16; e++) if (m_free[e]) n++;
    return n;
  endfunction

  task automatic model_reset();
    for (int e = 0; e < 16; e++) m_free[e] = 1'b1;
    last_flush = 1'b0;
    last_rv[0] = 1'b0;
    last_rv[1] = 1'b0;
    last_alloc.delete();
  endtask

  // Apply the previous cycle's inputs to the reference state.
  task automatic commit();
    if (last_flush) begin
      for (int e = 0; e < 16; e++) m_free[e] = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) if (last_rv[p]) m_free[last_ra[p]] = 1'b1;
      foreach (last_alloc[j]) m_free[last_alloc[j]] = 1'b0;
    end
    last_alloc.delete();
  endtask

  function automatic exp_t expect_now(input logic [3:0] req, input logic [1:0] rv,
                                      input logic [7:0] ra, input logic fl);
    exp_t x;
    int   list[$];
    int   nreq;
    int   k;
    for (int e = 0; e < 16; e++) begin
      bit relsd;
      relsd = (rv[0] && ra[3:0] == e[3:0]) || (rv[1] && ra[7:4] == e[3:0]);
      if (m_free[e] || (BYP && relsd)) list.push_back(e);
    end
    nreq    = $countones(req);
    x.req   = req;
    x.ready = !fl && (nreq <= list.size());
    x.valid = x.ready ? req : 4'b0;
    x.addrs = '0;
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (req[i]) begin
        if (k < list.size()) x.addrs[i*4 +: 4] = 4'(list[k]);
        k++;
      end
    end
    x.cnt   = 5'(model_count());
    x.full  = (model_count() == 0);
    x.empty = (model_count() == 16);
    x.free  = model_vec();
    return x;
  endfunction

  task automatic cycle(input logic [3:0] req, input logic [1:0] rv,
                       input logic [7:0] ra, input logic fl);
    exp_t x;
    @(posedge clk);
    commit();
    #1;
    rst_n     = 1'b1;
    alloc_req = req;
    rel_vld   = rv;
    rel_addr  = ra;
    flush     = fl;
    x = expect_now(req, rv, ra, fl);
    exp_q.push_back(x);
    last_flush = fl;
    last_rv[0] = rv[0];
    last_rv[1] = rv[1];
    last_ra[0] = int'(ra[3:0]);
    last_ra[1] = int'(ra[7:4]);
    if (x.ready) begin
      for (int i = 0; i < 4; i++) if (req[i]) last_alloc.push_back(int'(x.addrs[i*4 +: 4]));
    end
  endtask

  task automatic mid_reset();
    exp_t x;
    @(posedge clk);
    commit();
    #1;
    rst_n = 1'b0;
    alloc_req = '0; rel_vld = '0; flush = 1'b0;
    model_reset();
    #1;
    chk("midrst_free_cnt", 32'(free_cnt), 32'd16);
    chk("midrst_ciq_free", 32'(dut.ciq_free), 32'hFFFF);
    x = expect_now(4'b0, 2'b0, 8'h0, 1'b0);
    exp_q.push_back(x);
  endtask

  // Drive the bitmap to exactly the free set 'want'.
  task automatic set_free(input logic [15:0] want);
    int rl[$];
    cycle(4'b0, 2'b0, 8'h0, 1'b1);
    for (int j = 0; j < 4; j++) cycle(4'b1111, 2'b0, 8'h0, 1'b0);
    for (int e = 0; e < 16; e++) if (want[e]) rl.push_back(e);
    while (rl.size() >= 2) begin
      int a0, a1;
      a0 = rl.pop_front();
      a1 = rl.pop_front();
      cycle(4'b0, 2'b11, {4'(a1), 4'(a0)}, 1'b0);
    end
    if (rl.size() == 1) cycle(4'b0, 2'b01, {4'h0, 4'(rl[0])}, 1'b0);
    cycle(4'b0, 2'b0, 8'h0, 1'b0);
  endtask

  // Monitor: the DUT presents a response every cycle; compare on negedge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        x = exp_q.pop_front();
        chk("sb_ready", 32'(alloc_ready), 32'(x.ready));
        chk("sb_valid", 32'(alloc_valid), 32'(x.valid));
        for (int i = 0; i < 4; i++) begin
          if (x.valid[i] || !x.req[i])
            chk($sformatf("sb_addr%0d", i), 32'(alloc_addr[i*4 +: 4]), 32'(x.addrs[i*4 +: 4]));
        end
        chk("sb_free_cnt", 32'(free_cnt), 32'(x.cnt));
        chk("sb_full", 32'(ciq_full), 32'(x.full));
        chk("sb_empty", 32'(ciq_empty), 32'(x.empty));
        chk("sb_ciq_free", 32'(dut.ciq_free), 32'(x.free));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free_cnt", 32'(free_cnt), 32'd16);
    chk("rst_empty", 32'(ciq_empty), 32'd1);
    chk("rst_full", 32'(ciq_full), 32'd0);
    chk("rst_ciq_free", 32'(dut.ciq_free), 32'hFFFF);

    // Four lowest entries from an empty queue.
    cycle(4'b1111, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t1_ready", 32'(alloc_ready), 32'd1);
    chk("t1_addr", 32'(alloc_addr), 32'h3210);
    cycle(4'b0, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t1_free_cnt", 32'(free_cnt), 32'd12);
    chk("t1_ciq_free", 32'(dut.ciq_free), 32'hFFF0);

    // Stall on shortage, then exact fit to full.
    set_free(16'h8210);
    cycle(4'b1111, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t2_stall", 32'(alloc_ready), 32'd0);
    cycle(4'b0111, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t2_addr", 32'(alloc_addr[11:0]), 32'hF94);
    cycle(4'b0, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t2_full", 32'(ciq_full), 32'd1);

    // Sparse request.
    set_free(16'h0224);
    cycle(4'b1010, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t3_valid", 32'(alloc_valid), 32'hA);
    chk("t3_slot1", 32'(alloc_addr[7:4]), 32'd2);
    chk("t3_slot3", 32'(alloc_addr[15:12]), 32'd5);

    // Duplicate release on a full queue with a same-cycle request.
    set_free(16'h0000);
    cycle(4'b0001, 2'b11, 8'h77, 1'b0);
    #1;
    chk("t4_ready", 32'(alloc_ready), 32'(BYP));
    if (BYP) chk("t4_addr", 32'(alloc_addr[3:0]), 32'd7);
    cycle(4'b0, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t4_free_cnt", 32'(free_cnt), BYP ? 32'd0 : 32'd1);

    // Flush beats allocation and release.
    set_free(16'h001F);
    cycle(4'b1111, 2'b11, 8'h98, 1'b1);
    #1;
    chk("t5_valid", 32'(alloc_valid), 32'd0);
    cycle(4'b0, 2'b0, 8'h0, 1'b0);
    #1;
    chk("t5_free_cnt", 32'(free_cnt), 32'd16);
    chk("t5_empty", 32'(ciq_empty), 32'd1);

    // Random soak.
    for (int c = 0; c < 10000; c++) begin
      logic [3:0] rq;
      logic [1:0] rv;
      logic [7:0] ra;
      logic       fl;
      if (c == 5000) mid_reset();
      rq = 4'($urandom_range(0, 15));
      rv = 2'($urandom_range(0, 3));
      for (int p = 0; p < 2; p++) begin
        int a;
        a = $urandom_range(0, 15);
        if ($urandom_range(0, 9) < 8) begin
          for (int t = 0; t < 16; t++) begin
            if (!m_free[(a + t) % 16] && !(last_alloc.size() > 0 && 0)) begin
              a = (a + t) % 16;
              break;
            end
          end
        end
        ra[p*4 +: 4] = 4'(a);
      end
      fl = ($urandom_range(0, 63) == 0);
      cycle(rq, rv, ra, fl);
    end

    cycle(4'b0, 2'b0, 8'h0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
